// File: rtl/ckbuf_div_pkg.sv
// -----------------------------------------------------------------------------
// ckbuf_div_pkg
// Shared types and helpers for the ckbuf divided-clock core.
//   ckbuf_div_state_e : per-channel run state (IDLE, RUN, STOPPING)
//   CH_IDX_W()        : channel-index width, clog2 with a floor of 1
//   DIV_W_DEFAULT     : default width of the half-period count
// -----------------------------------------------------------------------------
package ckbuf_div_pkg;

    localparam int DIV_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } ckbuf_div_state_e;

    // A single-channel build still needs a 1-bit channel select port.
    function automatic int CH_IDX_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ckbuf_div_chan.sv
// -----------------------------------------------------------------------------
// ckbuf_div_chan
// One divided-clock channel: run FSM, half-period counter, live and shadow
// divide ratios, and the pending-update flag.
// Optional build macro: CKBUF_DIV_PULSE_EN adds the pulse output.
// Ports:
//   clk, reset_n : source clock, asynchronous active-low reset
//   en           : run request (level)
//   wr_en        : accepted config write targeting this channel
//   wr_div       : new half-period count minus one
//   out          : divided clock, registered
//   active       : channel in RUN or STOPPING
//   pending      : shadow ratio not yet applied
//   pulse        : (CKBUF_DIV_PULSE_EN) one-cycle strobe with each out rise
// -----------------------------------------------------------------------------
module ckbuf_div_chan
    import ckbuf_div_pkg::*;
#(
    parameter int               DIV_W     = DIV_W_DEFAULT,
    parameter logic [DIV_W-1:0] RESET_DIV = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    output logic             out,
`ifdef CKBUF_DIV_PULSE_EN
    output logic             pulse,
`endif
    output logic             active,
    output logic             pending
);

    ckbuf_div_state_e state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] div_shadow_q, div_shadow_d;
    logic             pend_q, pend_d;
    logic             out_q, out_d;
    logic             active_q, active_d;
    logic             pulse_q, pulse_d;
    logic             terminal;

    // NOTE: every _d gets a default at the top of the block so no path leaves
    // it unassigned; a missed branch would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_cur_d    = div_cur_q;
        div_shadow_d = div_shadow_q;
        pend_d       = pend_q;
        out_d        = out_q;
        pulse_d      = 1'b0;
        terminal     = (cnt_q == div_cur_q);

        // A write is only ever accepted while pend_q is clear, so it can never
        // collide with the shadow being consumed below in the same cycle.
        if (wr_en) begin
            div_shadow_d = wr_div;
            pend_d       = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                out_d = 1'b0;
                if (pend_q) begin
                    div_cur_d = div_shadow_q;
                    pend_d    = 1'b0;
                end
                if (en) begin
                    state_d = RUN;
                end
            end

            RUN, STOPPING: begin
                if (!en && !out_q) begin
                    // Low phase can be abandoned without shortening any pulse.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (terminal) begin
                        cnt_d = '0;
                        out_d = !out_q;
                        if (out_q) begin
                            // Falling edge is the period boundary: ratio swap point.
                            if (pend_q) begin
                                div_cur_d = div_shadow_q;
                                pend_d    = 1'b0;
                            end
                        end else begin
                            // Rising toggle only reachable in RUN with en high.
                            pulse_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end

                    // Re-assert while stopping resumes with the counter untouched.
                    if (en) begin
                        state_d = RUN;
                    end else if (terminal) begin
                        state_d = IDLE;
                    end else begin
                        state_d = STOPPING;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase

        active_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_cur_q    <= RESET_DIV;
            div_shadow_q <= RESET_DIV;
            pend_q       <= 1'b0;
            out_q        <= 1'b0;
            active_q     <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_cur_q    <= div_cur_d;
            div_shadow_q <= div_shadow_d;
            pend_q       <= pend_d;
            out_q        <= out_d;
            active_q     <= active_d;
            pulse_q      <= pulse_d;
        end
    end

    assign out     = out_q;
    assign active  = active_q;
    assign pending = pend_q;

`ifdef CKBUF_DIV_PULSE_EN
    assign pulse = pulse_q;
`else
    logic unused_pulse;
    assign unused_pulse = pulse_q;
`endif

endmodule

// File: rtl/ckbuf_div_core.sv
// -----------------------------------------------------------------------------
// ckbuf_div_core
// NUM_CH independent divided-clock channels from one fabric clock, each with a
// runtime-programmable even divide ratio, glitch-free stop and period-aligned
// ratio updates. This level holds config decode, ready mux and output buses.
// Optional build macro: CKBUF_DIV_PULSE_EN adds ck_pulse.
// Ports:
//   clk, reset_n    : source clock, asynchronous active-low reset
//   ch_en           : per-channel run request (level)
//   cfg_valid/ready : config handshake; ready reflects the addressed channel
//   cfg_ch, cfg_div : target channel and new half-period count minus one
//   ckbuf_core_out  : divided clocks, registered, 50% duty
//   ck_pulse        : (CKBUF_DIV_PULSE_EN) strobe with each rising toggle
//   ch_active       : channel running (including STOPPING)
//   upd_pending     : shadow ratio not yet applied
// -----------------------------------------------------------------------------
module ckbuf_div_core
    import ckbuf_div_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int DIV_W     = DIV_W_DEFAULT,
    parameter  int RESET_DIV = 0,
    localparam int CH_W      = CH_IDX_W(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] ckbuf_core_out,
`ifdef CKBUF_DIV_PULSE_EN
    output logic [NUM_CH-1:0] ck_pulse,
`endif
    output logic [NUM_CH-1:0] ch_active,
    output logic [NUM_CH-1:0] upd_pending
);

    // The map covers every encodable cfg_ch; unimplemented channels read as
    // ready so writes to them complete and are dropped.
    localparam int CH_SPAN = 1 << CH_W;

    logic [CH_SPAN-1:0] ready_map;
    logic [NUM_CH-1:0]  wr_en;
    logic               cfg_fire;

    always_comb begin
        ready_map = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            ready_map[i] = ~upd_pending[i];
        end
    end

    assign cfg_ready = ready_map[cfg_ch];
    assign cfg_fire  = cfg_valid && cfg_ready;

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_en[i] = cfg_fire && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ckbuf_div_chan #(
            .DIV_W     (DIV_W),
            .RESET_DIV (DIV_W'(RESET_DIV))
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (ch_en[g]),
            .wr_en   (wr_en[g]),
            .wr_div  (cfg_div),
            .out     (ckbuf_core_out[g]),
`ifdef CKBUF_DIV_PULSE_EN
            .pulse   (ck_pulse[g]),
`endif
            .active  (ch_active[g]),
            .pending (upd_pending[g])
        );
    end

endmodule

// File: doc/ckbuf_div_core.md
Name: ckbuf_div_core

Overview:
Parametrised successor to the single-channel clock buffer primitive. It provides NUM_CH independent divided-clock channels, all derived from one fabric clock. Each channel has a runtime-programmable even divide ratio, glitch-free enable/disable and period-aligned ratio updates. It sits in the ckbuf logical tile as the core primitive.

Parameters:
NUM_CH, 4, number of divided-clock channels (1..16)
DIV_W, 8, width of per-channel half-period count; half period = cfg_div+1 cycles
RESET_DIV, 0, cfg_div value loaded into every channel at reset (divide-by-2)

Ports:
clk  input  1  source clock, all logic rising-edge
reset_n  input  1  asynchronous active-low reset
ch_en  input  NUM_CH  per-channel run request (level)
cfg_valid  input  1  config request valid
cfg_ready  output  1  config accepted when cfg_valid && cfg_ready
cfg_ch  input  clog2(NUM_CH) (min 1)  target channel
cfg_div  input  DIV_W  new half-period count minus one
ckbuf_core_out  output  NUM_CH  divided clocks, registered, 50% duty
ch_active  output  NUM_CH  channel running (including STOPPING)
upd_pending  output  NUM_CH  shadow ratio not yet applied

Behaviour:
- Reset: all outputs 0; cfg_ready=1; div_cur=div_shadow=RESET_DIV; counters 0; all channels IDLE.
- Per-channel FSM: IDLE, RUN, STOPPING.
- IDLE→RUN on ch_en=1. Counter starts at 0, out=0. The first out rising edge is registered (div_cur+1) cycles after the cycle ch_en is sampled high.
- RUN: counter increments each cycle. At count==div_cur: counter←0, out toggles. Period = 2*(div_cur+1) cycles.
- RUN with ch_en=0:
  - out=0 → IDLE the next cycle, counter cleared.
  - out=1 → STOPPING.
- STOPPING: completes the high phase. At terminal count, out 1→0 and the channel goes to IDLE. If ch_en returns high during STOPPING, the channel goes back to RUN with no phase disturbance.
- No output pulse is ever shorter than (div_cur+1) cycles. out changes only at a terminal count or on the IDLE clear.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready. It writes div_shadow[cfg_ch] and sets upd_pending[cfg_ch].
  - cfg_ready = !upd_pending[cfg_ch]. It is combinational on cfg_ch, so a write to a channel with a pending update stalls.
  - cfg_ch ≥ NUM_CH: transfer accepted and discarded, no state change.
- Ratio application:
  - RUN/STOPPING: div_cur←div_shadow at the terminal count where out toggles 1→0 (period boundary). upd_pending clears the same cycle.
  - IDLE: applied the cycle after acceptance.
- Simultaneous events:
  - Acceptance on the same cycle as the boundary: the new value goes to the shadow only and applies at the next boundary.
  - ch_en falling on the terminal-count cycle with out=1: the toggle to 0 happens and the channel goes to IDLE.
- Counter width DIV_W; never exceeds div_cur, so no wrap. A div_cur reduction takes effect only from counter 0.
- Reset asserted mid-operation clears everything asynchronously; a pending shadow is lost.

Optional Feature:
- Macro: CKBUF_DIV_PULSE_EN.
- Defined: adds output ck_pulse [NUM_CH], a registered one-cycle strobe coincident with each out 0→1 toggle, for clock-enable style fabric use. Reset value 0. The strobe is suppressed in STOPPING and IDLE.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package ckbuf_div_pkg holds:
  - state enum ckbuf_div_state_e {IDLE, RUN, STOPPING}
  - CH_IDX_W function (clog2 with min 1)
  - DIV_W default constant
- Sub-module ckbuf_div_chan: one channel (FSM, counter, div_cur/div_shadow, pending flag), instantiated NUM_CH times.
- The top holds the cfg decode, the ready mux and output concatenation.

Test Plan:
- Reset, ch_en[0]=1, RESET_DIV=0 → out[0] first rises 1 cycle after en sampled, toggles every cycle (period 2); others stay 0.
- Channel 1: cfg_div=3 while IDLE, then enable → period 8 (4 high, 4 low); ch_active[1]=1; upd_pending[1] cleared 1 cycle after acceptance.
- Channel 0 running at div 3: write cfg_div=1 mid high phase → current period finishes at 8 cycles; next period is 4; upd_pending high until that boundary; a second write meanwhile sees cfg_ready=0.
- ch_en[2] dropped 1 cycle into a 4-cycle high phase → out stays high 3 more cycles, falls, ch_active[2]=0. A re-assert during STOPPING keeps the period unbroken.
- reset_n pulsed low mid-run with a pending update → all outputs 0 immediately; after release div_cur=RESET_DIV and upd_pending=0.
- With CKBUF_DIV_PULSE_EN, div=2 → ck_pulse one cycle every 6 cycles, aligned to the out rising edge; none after disable.
